inst_encoder: RTL

Inverse of the core's immediate decoder. It accepts decoded RV32I instruction fields on a valid/ready input, packs them into 32-bit instruction words with immediate range checking, and buffers the words in a small FIFO on a valid/ready output. It sits between the debug/program-loader logic and the instruction memory write port, and is used to inject self-generated instruction streams into the core.

---
 rtl/rv_enc_pkg.sv | 45 ++++
 rtl/sync_fifo.sv | 87 ++++++++
 rtl/inst_encoder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg
// Shared definitions for the RV32I instruction encoder and the decoder side:
//   - fmt_e     : instruction format codes carried on in_fmt (6 and 7 unused)
//   - OP_*      : base opcode constants
//   - ENTRY_W   : width of one buffered {inst, err} entry
//   - entry_t   : packed view of one buffered entry
//   - upper_uniform() : sign-run check used by the immediate range checks
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam int ENTRY_W = 33;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } entry_t;

  // True when imm[31:lsb] are all ones or all zeros, i.e. the value is a
  // correctly sign-extended quantity of (lsb+1) bits.
  function automatic logic upper_uniform(input logic [31:0] imm,
                                         input int unsigned lsb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << lsb;
    return ((imm & mask) == mask) || ((imm & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with valid/ready on both sides.
// Parameters:
//   WIDTH : entry width in bits
//   DEPTH : number of entries, power of two, at least 2
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   flush         : synchronous clear of both pointers
//   wr_valid/ready: write side; wr_ready is low during reset, when full or
//                   while flush is high
//   wr_data       : entry written on wr_valid & wr_ready
//   rd_valid/ready: read side; rd_valid means the head entry is present
//   rd_data       : head entry (raw storage, not gated by rd_valid)
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             out_of_reset;
  logic             full;
  logic             empty;
  logic             do_write;
  logic             do_read;

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ready = out_of_reset & ~full & ~flush;
  assign rd_valid = ~empty;
  assign rd_data  = mem[rd_ptr[AW-1:0]];
  assign do_write = wr_valid & wr_ready;
  assign do_read  = rd_valid & rd_ready;

  // Holds wr_ready low while reset is asserted and releases it on the first
  // clock edge after reset goes away.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  // Pointer update. Flush wins over any read in the same cycle; a write
  // cannot coincide with flush because wr_ready is low then.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage array; contents need no reset since rd_valid qualifies them.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder
// Packs decoded RV32I fields into 32-bit instruction words, range-checks the
// immediate and queues {inst, err} in a small output FIFO.
// Parameters:
//   FIFO_DEPTH : output buffer entries (power of two, at least 2)
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   flush                : synchronous clear of the output buffer
//   in_valid / in_ready  : field bundle handshake
//   in_fmt               : format code (see rv_enc_pkg::fmt_e)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm : fields
//   out_valid / out_ready: encoded word handshake
//   out_inst, out_err    : head word and its range-check flag, 0 when idle
//   count                : output handshakes since reset, wraps at 16 bits
module inst_encoder
  import rv_enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] count
);

  logic [31:0]        enc_inst;
  logic               enc_ok;
  entry_t             wr_entry;
  entry_t             head;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic               fifo_rd_valid;

  // Field packing and immediate range check for each format. Illegal
  // format codes fall through to the default and are flagged as errors.
  always_comb begin
    enc_inst = 32'h0;
    enc_ok   = 1'b0;
    case (in_fmt)
      FMT_R: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_ok   = 1'b1;
      end
      FMT_I: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_ok   = upper_uniform(in_imm, 11);
      end
      FMT_S: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                    in_opcode};
        enc_ok   = upper_uniform(in_imm, 11);
      end
      FMT_B: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_ok   = upper_uniform(in_imm, 12) & ~in_imm[0];
      end
      FMT_U: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        enc_ok   = (in_imm[11:0] == 12'h0);
      end
      FMT_J: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, in_opcode};
        enc_ok   = upper_uniform(in_imm, 20) & ~in_imm[0];
      end
      default: begin
        enc_inst = 32'h0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  // A failed check stores an all-zero word so the consumer never sees a
  // partially valid encoding.
  always_comb begin
    wr_entry.inst = enc_ok ? enc_inst : 32'h0;
    wr_entry.err  = ~enc_ok;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (wr_entry),
    .rd_valid (fifo_rd_valid),
    .rd_ready (out_ready),
    .rd_data  (fifo_rd_data)
  );

  assign head      = entry_t'(fifo_rd_data);
  assign out_valid = fifo_rd_valid;
  assign out_inst  = fifo_rd_valid ? head.inst : 32'h0;
  assign out_err   = fifo_rd_valid ? head.err  : 1'b0;

  // Output handshake counter; flush leaves it alone, only reset clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 16'h0;
    end else if (fifo_rd_valid && out_ready) begin
      count <= count + 16'h1;
    end
  end

endmodule
